// File: rtl/mult_div_unit_if.sv
// Bus between issue/control logic and the multiply/divide unit.
// Carries operands and op select, the start/busy/done handshake,
// the MTHI/MTLO write strobes and the HI/LO result registers.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             wr_hi;
    logic             wr_lo;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             div_by_zero;

    // Control/issue side drives requests and observes status and results.
    modport master (
        output start, op, operand_a, operand_b, wr_hi, wr_lo,
        input  busy, done, hi, lo, div_by_zero
    );

    // The unit itself consumes requests and produces status and results.
    modport slave (
        input  start, op, operand_a, operand_b, wr_hi, wr_lo,
        output busy, done, hi, lo, div_by_zero
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Signed ops work on operand magnitudes and fix up signs at the end,
// so one unsigned datapath serves MULT, MULTU, DIV and DIVU.
// Every op takes the same 34 cycles from acceptance to done.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input logic          clk,
    input logic          clr_n,
    mult_div_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_count;
    logic [1:0]         r_op;
    logic               r_signA;
    logic               r_signB;
    logic [WIDTH-1:0]   r_opA;
    logic [WIDTH-1:0]   r_opB;
    logic [WIDTH-1:0]   r_origA;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;
    logic               r_dbz;

    logic               w_accept;
    logic               w_isSignedIn;
    logic               w_isDivIn;
    logic [WIDTH-1:0]   w_absA;
    logic [WIDTH-1:0]   w_absB;
    logic [WIDTH-1:0]   w_mulAddend;
    logic [WIDTH:0]     w_mulSum;
    logic [WIDTH:0]     w_remShift;
    logic [WIDTH:0]     w_remDiff;
    logic [2*WIDTH-1:0] w_prodNeg;
    logic [WIDTH-1:0]   w_quotNeg;
    logic [WIDTH-1:0]   w_remNeg;
    logic               w_negResult;

    // A start is only taken when no operation occupies the datapath.
    assign w_accept     = bus.start && ((r_state == IDLE) || (r_state == DONE));
    assign w_isSignedIn = ~bus.op[0];
    assign w_isDivIn    = bus.op[1];
    assign w_absA = (w_isSignedIn && bus.operand_a[WIDTH-1]) ? -bus.operand_a : bus.operand_a;
    assign w_absB = (w_isSignedIn && bus.operand_b[WIDTH-1]) ? -bus.operand_b : bus.operand_b;

    // Shift-add: the multiplier sits in the low half and is consumed LSB first.
    assign w_mulAddend = r_acc[0] ? r_opA : {WIDTH{1'b0}};
    assign w_mulSum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_mulAddend};

    // Restoring divide: dividend bits shift MSB first from the low half into the remainder.
    assign w_remShift = {r_rem, r_acc[WIDTH-1]};
    assign w_remDiff  = w_remShift - {1'b0, r_opB};

    assign w_prodNeg   = -r_acc;
    assign w_quotNeg   = -r_acc[WIDTH-1:0];
    assign w_remNeg    = -r_rem;
    assign w_negResult = r_signA ^ r_signB;

    // Control FSM, iteration datapath and HI/LO registers with registered status outputs.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_count <= '0;
            r_op    <= '0;
            r_signA <= 1'b0;
            r_signB <= 1'b0;
            r_opA   <= '0;
            r_opB   <= '0;
            r_origA <= '0;
            r_acc   <= '0;
            r_rem   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dbz   <= 1'b0;
        end else begin
            if (!r_busy && bus.wr_hi) r_hi <= bus.operand_a;
            if (!r_busy && bus.wr_lo) r_lo <= bus.operand_a;

            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (w_accept) begin
                        r_state <= CALC;
                        r_busy  <= 1'b1;
                        r_count <= '0;
                        r_op    <= bus.op;
                        r_signA <= w_isSignedIn & bus.operand_a[WIDTH-1];
                        r_signB <= w_isSignedIn & bus.operand_b[WIDTH-1];
                        r_opA   <= w_absA;
                        r_opB   <= w_absB;
                        r_origA <= bus.operand_a;
                        r_rem   <= '0;
                        r_acc   <= {{WIDTH{1'b0}}, (w_isDivIn ? w_absA : w_absB)};
                        r_dbz   <= w_isDivIn && (bus.operand_b == '0);
                    end else begin
                        r_state <= IDLE;
                    end
                end
                CALC: begin
                    if (r_op[1]) begin
                        if (!w_remDiff[WIDTH]) begin
                            r_rem <= w_remDiff[WIDTH-1:0];
                            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b1};
                        end else begin
                            r_rem <= w_remShift[WIDTH-1:0];
                            r_acc[WIDTH-1:0] <= {r_acc[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        r_acc <= {w_mulSum, r_acc[WIDTH-1:1]};
                    end
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) r_state <= FIX;
                end
                FIX: begin
                    if (r_op[1]) begin
                        if (r_dbz) begin
                            r_hi <= r_origA;
                            r_lo <= '1;
                        end else begin
                            r_lo <= w_negResult ? w_quotNeg : r_acc[WIDTH-1:0];
                            r_hi <= r_signA ? w_remNeg : r_rem;
                        end
                    end else begin
                        {r_hi, r_lo} <= w_negResult ? w_prodNeg : r_acc;
                    end
                    r_count <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= DONE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed vector table, randomized ops
// against an arithmetic reference model, and hand-written sequences for
// ignored requests, MTHI/MTLO writes and reset abort.
module tb_mult_div_unit;
    logic clk   = 1'b0;
    logic clr_n = 1'b0;

    int numChecks = 0;
    int numFails  = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        logic        expDz;
        string       name;
    } vec_t;

    vec_t vecs[11];

    mult_div_unit_if #(.WIDTH(32)) bus();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk  (clk),
        .clr_n(clr_n),
        .bus  (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference results straight from the arithmetic definition of each op.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic dz);
        longint sa, sb, p, q, r;
        longint unsigned ua, ub, up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        dz = 1'b0;
        h  = '0;
        l  = '0;
        case (op)
            2'b00: begin
                p = sa * sb;
                h = p[63:32];
                l = p[31:0];
            end
            2'b01: begin
                up = ua * ub;
                h  = up[63:32];
                l  = up[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    dz = 1'b1;
                    h  = a;
                    l  = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    q = sa / sb;
                    r = sa % sb;
                    h = r[31:0];
                    l = q[31:0];
                end else begin
                    up = ua / ub;
                    h  = 32'(ua % ub);
                    l  = up[31:0];
                end
            end
        endcase
    endfunction

    // Present one request for exactly one edge; returns #1 after the accepting edge.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.start     = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    // Run one op and check handshake timing, HI/LO hold, and results; returns in the done cycle.
    task automatic runOp(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expHi, input logic [31:0] expLo, input logic expDz,
                         input string name);
        logic [31:0] prevHi, prevLo;
        int  cyc;
        bit  busyOk, holdOk;
        prevHi = bus.hi;
        prevLo = bus.lo;
        applyStimulus(op, a, b);
        checkOutput({name, " done low at T+1"}, 32'(bus.done), 32'd0);
        checkOutput({name, " div_by_zero at T+1"}, 32'(bus.div_by_zero), 32'(expDz));
        busyOk = 1'b1;
        holdOk = 1'b1;
        cyc    = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            if (bus.busy !== 1'b1) busyOk = 1'b0;
            if (bus.hi !== prevHi || bus.lo !== prevLo) holdOk = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput({name, " latency"}, 32'(cyc), 32'd34);
        checkOutput({name, " busy held T+1..T+33"}, 32'(busyOk), 32'd1);
        checkOutput({name, " hi/lo held in CALC"}, 32'(holdOk), 32'd1);
        checkOutput({name, " busy low at done"}, 32'(bus.busy), 32'd0);
        checkOutput({name, " hi"}, bus.hi, expHi);
        checkOutput({name, " lo"}, bus.lo, expLo);
        checkOutput({name, " div_by_zero"}, 32'(bus.div_by_zero), 32'(expDz));
    endtask

    initial begin
        logic [31:0] mHi, mLo, ra, rb, savedHi;
        logic [1:0]  rop;
        logic        mDz;
        int          cyc;
        bit          sawDone;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu max"};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult -3*7"};
        vecs[2]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult min*min"};
        vecs[3]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div -7/2"};
        vecs[4]  = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0, "divu 100/7"};
        vecs[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div overflow"};
        vecs[6]  = '{2'b11, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1, "divu by zero"};
        vecs[7]  = '{2'b01, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0, "multu 2*3"};
        vecs[8]  = '{2'b10, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div 7/-2"};
        vecs[9]  = '{2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0, "div -7/-2"};
        vecs[10] = '{2'b10, 32'hFFFF_FFF0, 32'd0,         32'hFFFF_FFF0, 32'hFFFF_FFFF, 1'b1, "div neg by zero"};

        bus.start     = 1'b0;
        bus.op        = 2'b00;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.wr_hi     = 1'b0;
        bus.wr_lo     = 1'b0;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", 32'(bus.busy), 32'd0);
        checkOutput("reset done", 32'(bus.done), 32'd0);
        checkOutput("reset hi", bus.hi, 32'd0);
        checkOutput("reset lo", bus.lo, 32'd0);
        checkOutput("reset div_by_zero", 32'(bus.div_by_zero), 32'd0);
        clr_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed vectors, issued back-to-back from each done cycle.
        for (int i = 0; i < 11; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].expHi, vecs[i].expLo, vecs[i].expDz, vecs[i].name);
        end

        // Randomized ops against the reference model, including zero divisors and edge operands.
        for (int i = 0; i < 24; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 15));
                2: ra = 32'h8000_0000;
                3: rb = 32'hFFFF_FFFF;
                default: ;
            endcase
            model(rop, ra, rb, mHi, mLo, mDz);
            runOp(rop, ra, rb, mHi, mLo, mDz, $sformatf("random %0d op%0d", i, rop));
        end

        // Ignored start and MTHI while busy.
        applyStimulus(2'b01, 32'd3, 32'd4);
        cyc = 1;
        while (bus.done !== 1'b1 && cyc < 60) begin
            bus.start = (cyc == 9);
            bus.wr_hi = (cyc == 11);
            if (cyc == 9) begin
                bus.operand_a = 32'd9;
                bus.operand_b = 32'd9;
            end
            if (cyc == 11) bus.operand_a = 32'h1234;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.start = 1'b0;
        bus.wr_hi = 1'b0;
        checkOutput("busy-ignore latency", 32'(cyc), 32'd34);
        checkOutput("busy-ignore hi", bus.hi, 32'd0);
        checkOutput("busy-ignore lo", bus.lo, 32'd12);

        // MTHI+MTLO together while idle, then MTLO alone.
        @(posedge clk);
        #1;
        bus.wr_hi     = 1'b1;
        bus.wr_lo     = 1'b1;
        bus.operand_a = 32'h5555_AAAA;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
        checkOutput("mthi+mtlo hi", bus.hi, 32'h5555_AAAA);
        checkOutput("mthi+mtlo lo", bus.lo, 32'h5555_AAAA);
        savedHi       = bus.hi;
        bus.wr_lo     = 1'b1;
        bus.operand_a = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        bus.wr_lo = 1'b0;
        checkOutput("mtlo lo", bus.lo, 32'h0000_ABCD);
        checkOutput("mtlo hi unchanged", bus.hi, savedHi);

        // Reset in the middle of a divide aborts it without a done pulse.
        applyStimulus(2'b11, 32'd5, 32'd0);
        checkOutput("abort div_by_zero set", 32'(bus.div_by_zero), 32'd1);
        cyc = 1;
        while (cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        clr_n = 1'b0;
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        checkOutput("abort busy", 32'(bus.busy), 32'd0);
        checkOutput("abort hi", bus.hi, 32'd0);
        checkOutput("abort lo", bus.lo, 32'd0);
        checkOutput("abort div_by_zero", 32'(bus.div_by_zero), 32'd0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) sawDone = 1'b1;
            @(posedge clk);
            #1;
        end
        checkOutput("abort no done/busy in 40 cycles", 32'(sawDone), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end
endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Multi-cycle integer multiply/divide unit with HI/LO result registers, directly downstream of the register file.
- Consumes the two register-file read buses as operands and executes MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
- Holds the 64-bit result in HI/LO for later move-from-HI/LO reads.
- Uses a start/busy/done handshake so control can stall issue while an operation is in flight.

Parameters:
- WIDTH, 32, operand width and width of each of HI and LO. The only verified value is 32.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- clr_n  input  1  synchronous active-low reset.
- start  input  1  request to begin the operation selected by op; accepted only when busy=0.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with start.
- operand_a  input  WIDTH  multiplicand/dividend; register-file read_data_1. Sampled with start.
- operand_b  input  WIDTH  multiplier/divisor; register-file read_data_2. Sampled with start.
- wr_hi  input  1  MTHI: load HI from operand_a; ignored while busy=1.
- wr_lo  input  1  MTLO: load LO from operand_a; ignored while busy=1.
- busy  output  1  operation in progress.
- done  output  1  single-cycle pulse; HI/LO hold the new result.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.
- div_by_zero  output  1  sticky flag; last accepted divide had divisor 0.

Behaviour:
- Reset: clr_n=0 at a rising edge forces the following, with priority over everything:
  - state=IDLE; hi=0, lo=0, busy=0, done=0, div_by_zero=0; iteration counter=0.
  - Any in-flight operation is aborted and produces no done.
- States:
  - IDLE: waiting for start.
  - CALC: 32 iterations.
  - FIX: sign correction and write of HI/LO.
  - DONE: one cycle, done=1.
- Acceptance: start=1 in IDLE or DONE at edge T.
  - Latch op, the sign flags and the absolute values of the operands. Absolute values apply only for the signed ops MULT/DIV; MULTU/DIVU latch operands unchanged.
  - Clear div_by_zero; set it to 1 if op is DIV/DIVU and operand_b=0.
  - Go to CALC with counter=0.
- CALC, one step per cycle for 32 cycles:
  - Multiply: unsigned shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract, 33-bit partial remainder.
  - After count 31, go to FIX.
- FIX: write HI/LO, then go to DONE.
  - Signed multiply: negate the 64-bit product if the operand signs differ.
  - Signed divide: negate the quotient if the signs differ; give the remainder the dividend's sign. Quotient truncates toward zero.
  - Divide by zero: HI=operand_a as latched (original signed value), LO=all ones. The full latency still applies.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. This falls out of the absolute-value method.
- Timing:
  - busy=1 for cycles T+1..T+33.
  - HI/LO update at the end of T+33.
  - done=1 during T+34 only; busy=0 during T+34.
  - Fixed latency of 34 cycles from the accepting edge to done, for all ops.
- A start during DONE is accepted: back-to-back operation with no idle bubble.
- start while busy=1 is ignored. It does not queue and does not alter the latched operands.
- HI/LO hold their previous values throughout CALC. The intermediate accumulator is internal only.
- wr_hi/wr_lo when busy=0:
  - Load on the edge; both may be asserted together, and both load operand_a.
  - If start is also accepted on the same edge, wr_hi/wr_lo take effect for that edge. The later FIX overwrites them.
  - Both are ignored when busy=1.
- div_by_zero holds until the next accepted start or reset. It is never set by a multiply.

Test Plan:
1. MULTU a=0xFFFFFFFF, b=0xFFFFFFFF, start at T -> busy=1 T+1..T+33; done=1 at T+34 only; hi=0xFFFFFFFE, lo=0x00000001.
2. MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Immediately MULT a=0x80000000, b=0x80000000 started in the DONE cycle -> hi=0x40000000, lo=0, done 34 cycles later.
3. DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=100, b=7 -> lo=14, hi=2. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. DIVU a=5, b=0 -> div_by_zero=1 from T+1, hi=5, lo=0xFFFFFFFF at done. Next MULTU 2*3 -> div_by_zero=0 from its T+1, hi=0, lo=6.
5. Start MULTU 3*4 at T; second start with a=9, b=9 at T+10; wr_hi=1 with a=0x1234 at T+12 -> both ignored; result hi=0, lo=12 at T+34. wr_lo=1 with a=0xABCD when idle -> lo=0xABCD next cycle, hi unchanged.
6. Start DIVU at T; clr_n=0 at T+20 -> at T+21 busy=0, hi=lo=0, div_by_zero=0; no done pulse within 40 cycles without a new start.
